gshare_predictor: RTL
=====================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL have parameter HIST_W, default 7, meaning global history width and PHT index width.
REQ-002 The block SHALL have parameter PHT_DEPTH, default 2**HIST_W (128), meaning number of 2-bit counters.
REQ-003 The block SHALL have ports:
  clk  input  1  rising-edge clock.
  areset  input  1  asynchronous active-high reset.
  predict_valid  input  1  prediction request this cycle.
  predict_pc  input  HIST_W  branch PC bits used for the index.
  predict_taken  output  1  predicted direction.
  predict_history  output  HIST_W  global history used for this prediction.
  train_valid  input  1  training update this cycle.
  train_taken  input  1  resolved branch direction.
  train_mispredicted  input  1  resolved direction differs from prediction.
  train_history  input  HIST_W  history captured at prediction time.
  train_pc  input  HIST_W  PC of the resolved branch.

Function
REQ-004 The predict index SHALL be predict_pc XOR ghr and the train index SHALL be train_pc XOR train_history, both HIST_W bits wide with no carry.
REQ-005 predict_taken SHALL equal bit 1 of PHT[predict index] and predict_history SHALL equal ghr, combinationally, in the same cycle as the request; both outputs are don't-care when predict_valid=0.
REQ-006 Each PHT entry SHALL be a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-007 On a clock edge with train_valid=1, PHT[train index] SHALL increment if train_taken=1 and decrement if train_taken=0, saturating at 11 and 00.
REQ-008 If predict and train access the same index in one cycle, predict_taken SHALL use the pre-update counter value; the update is visible from the next cycle.
REQ-009 If train_valid=1 and train_mispredicted=1, ghr SHALL load {train_history[HIST_W-2:0], train_taken} on the next edge.
REQ-010 Otherwise, if predict_valid=1, ghr SHALL load {ghr[HIST_W-2:0], predict_taken} on the next edge.
REQ-011 When both REQ-009 and REQ-010 apply in the same cycle, misprediction recovery SHALL win and the concurrent prediction's history shift SHALL be discarded.
REQ-012 train_mispredicted SHALL be ignored when train_valid=0.
REQ-013 The ghr update SHALL shift left, dropping the MSB; bit 0 SHALL be the newest outcome.
REQ-014 Prediction latency SHALL be 0 cycles and training-to-visibility latency SHALL be 1 cycle.

Reset
REQ-015 While areset=1, ghr SHALL be 0 and every PHT entry SHALL be 01 (weak-NT), asynchronously and independent of clk.
REQ-016 Outputs after reset SHALL be predict_taken=0 and predict_history=0.
REQ-017 Asserting areset mid-operation SHALL discard all training and history state, with no partial update on the edge where reset deasserts.

Structure
REQ-018 A shared package bp_pkg SHALL hold HIST_W, the counter typedef ctr_t (2 bits) and the four counter-state constants.
REQ-019 The ghr and its priority update (REQ-009 to REQ-011) SHALL be one sub-module, branch_history_reg; the PHT and the counter logic SHALL stay in gshare_predictor.
REQ-020 The PHT SHALL be implemented in flops, not SRAM, so that REQ-015 holds.

Verification
REQ-021 Reset, then predict_pc=0x05 with predict_valid=1 -> predict_taken=0, predict_history=0x00; next cycle ghr=0x00.
REQ-022 Reset, then 2 cycles of train_valid=1, train_pc=0x05, train_history=0x00, train_taken=1, predict_valid=0 -> predict_pc=0x05 returns predict_taken=1 (counter 11).
REQ-023 Saturation: 5 taken trains on one index followed by 1 not-taken train -> counter 10, predict_taken=1; 3 more not-taken trains -> counter 00, and a further not-taken train leaves it at 00.
REQ-024 Recovery priority: drive ghr to 0x55 via predictions, then in one cycle assert predict_valid=1 with train_valid=1, train_mispredicted=1, train_history=0x0F, train_taken=1 -> ghr=0x1F next cycle.
REQ-025 Same-index collision: PHT[0x03]=01; predict at index 0x03 while training taken at index 0x03 -> predict_taken=0 that cycle, 1 the following cycle.
REQ-026 Reset mid-stream: after training several entries to 11, pulse areset between clock edges -> ghr=0 immediately and every index predicts 0.

Source files
------------

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the gshare branch predictor:
//   HIST_W   - default global history / PHT index width
//   ctr_t    - 2-bit saturating direction counter
//   CTR_*    - the four counter states (strong/weak not-taken/taken)
//   ctr_update - saturating increment (taken) / decrement (not taken)
// -----------------------------------------------------------------------------
package bp_pkg;

  localparam int HIST_W = 7;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Move one step toward the resolved direction, holding at the extremes.
  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_history_reg.sv
// -----------------------------------------------------------------------------
// branch_history_reg
// Global history register with misprediction-recovery priority.
//   clk, areset           - clock, asynchronous active-high reset (ghr -> 0)
//   predict_valid_i       - a prediction was made this cycle
//   predict_taken_i       - direction that prediction produced
//   train_valid_i         - a branch resolved this cycle
//   train_mispredicted_i  - that branch was mispredicted (ignored without valid)
//   train_taken_i         - resolved direction
//   train_history_i       - history captured when the branch was predicted
//   ghr_o                 - current global history (bit 0 = newest outcome)
// -----------------------------------------------------------------------------
module branch_history_reg #(
  parameter int HIST_W = bp_pkg::HIST_W
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              predict_valid_i,
  input  logic              predict_taken_i,
  input  logic              train_valid_i,
  input  logic              train_mispredicted_i,
  input  logic              train_taken_i,
  input  logic [HIST_W-1:0] train_history_i,
  output logic [HIST_W-1:0] ghr_o
);
  import bp_pkg::*;

  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;

  // A misprediction rebuilds history from the snapshot taken at prediction
  // time plus the real outcome; any speculative shift from a prediction in
  // the same cycle is on the wrong path and is dropped.
  always_comb begin
    ghr_d = ghr_q;
    if (train_valid_i && train_mispredicted_i) begin
      ghr_d = {train_history_i[HIST_W-2:0], train_taken_i};
    end else if (predict_valid_i) begin
      ghr_d = {ghr_q[HIST_W-2:0], predict_taken_i};
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
// Gshare direction predictor: a flop-based table of 2-bit counters indexed by
// PC XOR global history.
//   clk, areset          - clock, asynchronous active-high reset
//   predict_valid        - prediction request this cycle
//   predict_pc           - PC bits hashed into the index
//   predict_taken        - predicted direction (combinational, same cycle)
//   predict_history      - history used for this prediction (= ghr)
//   train_valid          - training update this cycle
//   train_taken          - resolved direction
//   train_mispredicted   - resolved direction differed from prediction
//   train_history        - history captured at prediction time
//   train_pc             - PC of the resolved branch
//
// Valid semantics: predict_valid and train_valid are single-cycle strobes with
// no back-pressure; each asserted cycle is consumed on that clock edge. When
// predict_valid is low the predict outputs carry no meaning.
// -----------------------------------------------------------------------------
module gshare_predictor #(
  parameter int HIST_W    = bp_pkg::HIST_W,
  parameter int PHT_DEPTH = 2 ** HIST_W
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              predict_valid,
  input  logic [HIST_W-1:0] predict_pc,
  output logic              predict_taken,
  output logic [HIST_W-1:0] predict_history,
  input  logic              train_valid,
  input  logic              train_taken,
  input  logic              train_mispredicted,
  input  logic [HIST_W-1:0] train_history,
  input  logic [HIST_W-1:0] train_pc
);
  import bp_pkg::*;

  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] pred_idx;
  logic [HIST_W-1:0] train_idx;
  ctr_t              pht_q [PHT_DEPTH];
  ctr_t              train_ctr_d;

  assign pred_idx  = predict_pc ^ ghr;
  assign train_idx = train_pc ^ train_history;

  // Reads come straight from the flops, so a same-cycle train to the same
  // entry is only seen from the following cycle.
  assign predict_taken   = pht_q[pred_idx][1];
  assign predict_history = ghr;

  assign train_ctr_d = ctr_update(pht_q[train_idx], train_taken);

  // Flops rather than RAM so the whole table clears asynchronously.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= CTR_WNT;
      end
    end else if (train_valid) begin
      pht_q[train_idx] <= train_ctr_d;
    end
  end

  branch_history_reg #(
    .HIST_W(HIST_W)
  ) u_bhr (
    .clk                  (clk),
    .areset               (areset),
    .predict_valid_i      (predict_valid),
    .predict_taken_i      (predict_taken),
    .train_valid_i        (train_valid),
    .train_mispredicted_i (train_mispredicted),
    .train_taken_i        (train_taken),
    .train_history_i      (train_history),
    .ghr_o                (ghr)
  );

endmodule
